// File: rtl/gf233_pkg.sv
// rtl/gf233_pkg.sv - shared constants, tag type and clog2 helper for the GF(2^233) multiplier scheduler
package gf233_pkg;

  localparam int GF_W     = 116;
  localparam int GF_PW    = 232;
  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with registered rotating pointer
module rr_arbiter
  import gf233_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          grant,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     transfer
);

  localparam int IDW = clog2(NREQ);

  logic [IDW-1:0] ptr;
  int             idx;

  // First valid requester at or after ptr, wrapping at NREQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    transfer = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!transfer && req_valid[idx]) begin
        transfer   = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mult116_rr_sched.sv
// rtl/mult116_rr_sched.sv - round-robin sharing of one pipelined mult116 with tag-routed responses
module mult116_rr_sched
  import gf233_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int W    = GF_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*W-1:0]          req_a,
  input  logic [NREQ*W-1:0]          req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic [W-1:0]               mul_a,
  output logic [W-1:0]               mul_b,
  input  logic [2*W-1:0]             mul_d,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [2*W-1:0]             rsp_d,
  output logic [clog2(LAT+3)-1:0]    in_flight,
  output logic                       busy
);

  localparam int IDW = clog2(NREQ);
  localparam int IFW = clog2(LAT + 3);

  logic [IDW-1:0] grant_id;
  logic           transfer;
  logic           rsp_fire;
  tag_t           tag_in;
  tag_t           tag_out;
  tag_t           tag_pipe [0:LAT];

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .grant    (req_ready),
    .grant_id (grant_id),
    .transfer (transfer)
  );

  // Operands hold when idle so the multiplier inputs do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (transfer) begin
      mul_a <= req_a[int'(grant_id)*W +: W];
      mul_b <= req_b[int'(grant_id)*W +: W];
    end
  end

  always_comb begin
    tag_in.valid = transfer;
    tag_in.id    = TAG_ID_W'(grant_id);
  end

  // Stage LAT lines up with the cycle in which mul_d carries this tag's product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_out = tag_pipe[LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_d     <= '0;
    end else if (tag_out.valid) begin
      rsp_valid <= NREQ'(1) << tag_out.id;
      rsp_d     <= mul_d;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign rsp_fire = |rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      in_flight <= in_flight + IFW'(transfer) - IFW'(rsp_fire);
    end
  end

  assign busy = (in_flight != '0);

endmodule

// File: tb/tb_mult116_rr_sched.sv
// tb/tb_mult116_rr_sched.sv - scoreboard bench for mult116_rr_sched (NREQ=4/LAT=2 and NREQ=2/LAT=0)
module tb_mult116_rr_sched;
  import gf233_pkg::*;

  localparam int W  = 116;
  localparam int PW = 232;
  localparam int N1 = 4;
  localparam int L1 = 2;
  localparam int N2 = 2;
  localparam int L2 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N1-1:0]   req_valid, req_ready, rsp_valid;
  logic [N1*W-1:0] req_a, req_b;
  logic [W-1:0]    mul_a, mul_b;
  logic [PW-1:0]   mul_d, rsp_d, mstage1, mstage2;
  logic [2:0]      in_flight;
  logic            busy;

  logic [N2-1:0]   req_valid2, req_ready2, rsp_valid2;
  logic [N2*W-1:0] req_a2, req_b2;
  logic [W-1:0]    mul_a2, mul_b2;
  logic [PW-1:0]   mul_d2, rsp_d2;
  logic [1:0]      in_flight2;
  logic            busy2;

  typedef struct {
    logic [3:0]    v;
    logic [PW-1:0] d;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]  b115;
  logic [W-1:0]  ones;
  logic [PW-1:0] p115, p230, pones;

  mult116_rr_sched #(.NREQ(N1), .LAT(L1), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_d(mul_d),
    .rsp_valid(rsp_valid), .rsp_d(rsp_d), .in_flight(in_flight), .busy(busy)
  );

  mult116_rr_sched #(.NREQ(N2), .LAT(L2), .W(W)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_a(req_a2), .req_b(req_b2),
    .req_ready(req_ready2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_d(mul_d2),
    .rsp_valid(rsp_valid2), .rsp_d(rsp_d2), .in_flight(in_flight2), .busy(busy2)
  );

  function automatic logic [PW-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) if (b[i]) r = r ^ (PW'(a) << i);
    return r;
  endfunction

  // Shared multiplier stand-ins: two-stage pipe for dut, combinational for dut2.
  always @(posedge clk) begin
    mstage1 <= clmul(mul_a, mul_b);
    mstage2 <= mstage1;
  end
  assign mul_d  = mstage2;
  assign mul_d2 = clmul(mul_a2, mul_b2);

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== '0) begin
      if (q1.size() == 0) chk("rsp1_unexpected", PW'(rsp_valid), '0);
      else begin
        e = q1.pop_front();
        chk("rsp1_valid", PW'(rsp_valid), PW'(e.v));
        chk("rsp1_d", rsp_d, e.d);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid2 !== '0) begin
      if (q2.size() == 0) chk("rsp2_unexpected", PW'(rsp_valid2), '0);
      else begin
        e = q2.pop_front();
        chk("rsp2_valid", PW'(rsp_valid2), PW'(e.v));
        chk("rsp2_d", rsp_d2, e.d);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0;
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && (q1.size() != 0 || q2.size() != 0); c++) next_cycle();
    chk("drain_pending", PW'(q1.size() + q2.size()), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ife [5] = '{1, 1, 1, 1, 0};
    b115  = W'(1) << 115;
    ones  = '1;
    p115  = PW'(1) << 115;
    p230  = PW'(1) << 230;
    pones = {{W{1'b0}}, {W{1'b1}}};
    req_valid = '0; req_a = '0; req_b = '0;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0;

    @(negedge clk);
    chk("reset_mul_a", PW'(mul_a), '0);
    chk("reset_mul_b", PW'(mul_b), '0);
    chk("reset_rsp_valid", PW'(rsp_valid), '0);
    chk("reset_rsp_d", rsp_d, '0);
    chk("reset_in_flight", PW'(in_flight), '0);
    chk("reset_busy", PW'(busy), '0);
    chk("reset_rsp_valid2", PW'(rsp_valid2), '0);

    // Single request from requester 2.
    do_reset();
    req_valid = 4'b0100;
    set_req(2, W'(1), b115);
    q1.push_back('{4'b0100, p115});
    @(negedge clk);
    chk("single_ready", PW'(req_ready), PW'(4'b0100));
    chk("single_if0", PW'(in_flight), '0);
    next_cycle();
    req_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("single_in_flight", PW'(in_flight), PW'(ife[c-1]));
      if (c == 1) begin
        chk("single_mul_a", PW'(mul_a), PW'(1));
        chk("single_mul_b", PW'(mul_b), PW'(b115));
      end
      if (c == 3) chk("single_early_rsp", PW'(rsp_valid), '0);
      if (c == 4) chk("single_rsp_cycle4", PW'(rsp_valid), PW'(4'b0100));
      next_cycle();
    end
    // Pointer now sits at 3, so 3 wins over 0.
    req_valid = 4'b1001;
    set_req(3, W'(2), W'(3));
    q1.push_back('{4'b1000, PW'(6)});
    @(negedge clk);
    chk("ptr_after_2", PW'(req_ready), PW'(4'b1000));
    next_cycle();
    req_valid = '0;
    drain();

    // All four requesters valid continuously.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      req_valid = 4'hF;
      for (int i = 0; i < N1; i++) set_req(i, W'(1) << i, W'(k / 4 + 1));
      q1.push_back('{4'(1) << (k % 4), PW'(k / 4 + 1) << (k % 4)});
      @(negedge clk);
      chk("rr_grant", PW'(req_ready), PW'(4'(1) << (k % 4)));
      if (k == 6) chk("rr_in_flight_max", PW'(in_flight), PW'(4));
      next_cycle();
    end
    req_valid = '0;
    drain();

    // Back-to-back on requester 0.
    do_reset();
    req_valid = 4'b0001;
    set_req(0, W'(3), W'(3));
    q1.push_back('{4'b0001, PW'(5)});
    @(negedge clk);
    chk("b2b_ready0", PW'(req_ready), PW'(4'b0001));
    next_cycle();
    set_req(0, b115, b115);
    q1.push_back('{4'b0001, p230});
    @(negedge clk);
    chk("b2b_ready1", PW'(req_ready), PW'(4'b0001));
    next_cycle();
    req_valid = '0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4 || c == 5) chk("b2b_rsp", PW'(rsp_valid), PW'(4'b0001));
      next_cycle();
    end
    drain();

    // Simultaneous accept and response at in_flight=3; busy tail.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      if (c <= 2 || c == 4) begin
        req_valid = 4'b0010;
        set_req(1, W'(1), W'(c + 5));
        q1.push_back('{4'b0010, PW'(c + 5)});
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (c == 4) begin
        chk("sim_if_before", PW'(in_flight), PW'(3));
        chk("sim_ready", PW'(req_ready), PW'(4'b0010));
        chk("sim_rsp", PW'(rsp_valid), PW'(4'b0010));
      end
      if (c == 5) chk("sim_if_after", PW'(in_flight), PW'(3));
      if (c == 8) begin
        chk("tail_busy_hi", PW'(busy), PW'(1));
        chk("tail_rsp", PW'(rsp_valid), PW'(4'b0010));
      end
      if (c == 9) chk("tail_busy_lo", PW'(busy), '0);
      next_cycle();
    end
    drain();

    // Reset while two operations are in flight.
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N1; i++) set_req(i, W'(7), W'(9));
    @(negedge clk);
    chk("mid_grant0", PW'(req_ready), PW'(4'b0001));
    next_cycle();
    @(negedge clk);
    chk("mid_grant1", PW'(req_ready), PW'(4'b0010));
    next_cycle();
    rst_n = 1'b0;
    req_valid = '0;
    q1.delete();
    @(negedge clk);
    chk("mid_mul_a", PW'(mul_a), '0);
    chk("mid_mul_b", PW'(mul_b), '0);
    chk("mid_in_flight", PW'(in_flight), '0);
    chk("mid_busy", PW'(busy), '0);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mid_no_stale_rsp", PW'(rsp_valid), '0);
      next_cycle();
    end
    req_valid = 4'hF;
    set_req(0, W'(5), W'(3));
    q1.push_back('{4'b0001, PW'(15)});
    @(negedge clk);
    chk("mid_ptr_restart", PW'(req_ready), PW'(4'b0001));
    next_cycle();
    req_valid = '0;
    drain();

    // Combinational multiplier, two requesters.
    do_reset();
    req_valid2 = 2'b01;
    req_a2[0 +: W] = ones;
    req_b2[0 +: W] = W'(1);
    q2.push_back('{4'b0001, pones});
    @(negedge clk);
    chk("lat0_ready", PW'(req_ready2), PW'(2'b01));
    next_cycle();
    req_valid2 = '0;
    @(negedge clk);
    chk("lat0_no_rsp_c1", PW'(rsp_valid2), '0);
    next_cycle();
    @(negedge clk);
    chk("lat0_rsp_c2", PW'(rsp_valid2), PW'(2'b01));
    next_cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
